leaf_rr_scheduler: RTL and testbench
====================================

Name: leaf_rr_scheduler

Overview:
- Round-robin scheduler that shares one execution slot among the 15 leaf instances of a generated hierarchy level (instances 0..14).
- Each leaf raises a request. The scheduler grants exactly one leaf at a time and holds the grant until that leaf signals done or a hold timeout expires.
- Sits beside the level wrapper and drives per-leaf enable/grant lines.

Parameters:
- N_REQ, 15, number of requesting leaf instances.
- IDX_W, 4, width of the grant index; must satisfy 2**IDX_W >= N_REQ.
- TIMEOUT, 255, maximum grant hold in cycles before forced release; range 1..2**16-1.
- CNT_W, 16, width of the hold counter and the per-run grant counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous and active-high.
- en  in  1  scheduler enable; low blocks new grants only.
- req  in  N_REQ  per-leaf request, level-sensitive.
- done  in  N_REQ  per-leaf completion; only the bit of the granted leaf is honoured.
- gnt  out  N_REQ  one-hot grant, registered.
- gnt_valid  out  1  high while any grant is active (equals OR of gnt).
- gnt_idx  out  IDX_W  index of the granted leaf; holds the last granted index when gnt_valid is low.
- timeout_pulse  out  1  one-cycle pulse when a grant is force-released.
- grant_cnt  out  CNT_W  total grants issued since reset; saturates at all-ones.

Behaviour:
- Reset (async assert, sync-released use): gnt=0, gnt_valid=0, gnt_idx=0, timeout_pulse=0, grant_cnt=0, state=IDLE, rr pointer=0, hold counter=0. Reset mid-grant drops gnt immediately, with no release cycle.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - If en=1 and req!=0, select the first set req bit scanning from ptr upward, with wrap from N_REQ-1 to 0.
  - Next cycle: state=GRANT, gnt[sel]=1, gnt_idx=sel, hold counter=0, grant_cnt+1.
  - Latency from req sample to gnt is 1 cycle.
  - Otherwise stay in IDLE.
- GRANT: hold counter increments each cycle.
  - done[gnt_idx]=1 -> RELEASE.
  - Hold counter reaches TIMEOUT-1 without done -> RELEASE with timeout flag set.
  - done and timeout in the same cycle -> done wins; no timeout_pulse.
  - done bits of non-granted leaves are ignored.
  - req[gnt_idx] dropping without done does not release the grant; only done or timeout releases.
  - en=0 has no effect on an active grant.
- RELEASE: gnt=0 for exactly one cycle. timeout_pulse=1 in this cycle iff the timeout flag is set. ptr = (gnt_idx+1) mod N_REQ. Next state is IDLE.
- Minimum re-grant spacing: grant, one release cycle, one IDLE arbitration cycle, then the next grant. Back-to-back grants are 2 cycles apart at the boundary.
- Fairness: a continuously requesting leaf waits at most N_REQ-1 other grants.
- Arithmetic:
  - ptr wrap uses explicit compare with N_REQ-1; no power-of-two assumption.
  - grant_cnt saturates at 2**CNT_W-1 and does not wrap.
- Invariants: gnt is one-hot or zero, and changes only at state transitions.

Decomposition:
- Shared package leaf_sched_pkg:
  - state enum type (IDLE, GRANT, RELEASE);
  - N_REQ_DEFAULT and TIMEOUT_DEFAULT constants;
  - a function for next-index wrap.
- One sub-module: leaf_rr_pick. It is combinational: given req and ptr, it returns found and sel_idx via a rotate / priority-find / un-rotate scheme. The FSM, counters and output registers live in leaf_rr_scheduler.

Test Plan:
- Single requester: reset, en=1, req=15'h0004, done[2] pulsed 5 cycles after gnt rises -> gnt=15'h0004 one cycle after req, gnt_idx=2, hold 6 cycles, one gnt=0 cycle, grant_cnt=1, timeout_pulse stays 0.
- Round-robin with wrap: req=all ones, each grant done after 1 cycle -> grant order 0,1,...,14,0. The second grant to leaf 0 follows 15 grants; grant_cnt=16 at that point.
- Timeout: TIMEOUT=8, req[7]=1, done never asserted -> gnt[7] high 8 cycles, then timeout_pulse=1 for one cycle with gnt=0, ptr=8. A subsequent req[7]|req[3] grants 3 before 7.
- Done/timeout collision: TIMEOUT=4, done[5] asserted in the 4th grant cycle -> release occurs, timeout_pulse=0. A done on a non-granted bit (done[6]) during the grant causes no release.
- Enable gating: grant active on leaf 1, en driven 0 -> grant completes normally on done. With req=15'h0300 held and en=0, no new grant appears. en=1 -> gnt=15'h0100 next cycle.
- Async reset mid-grant: rst asserted between clock edges while gnt=15'h0400 -> gnt=0, gnt_valid=0, grant_cnt=0 immediately without waiting for an edge. After release with req=15'h0401, leaf 0 is granted first (ptr=0).

Source files
------------

// File: rtl/leaf_sched_pkg.sv
// Shared definitions for the leaf round-robin scheduler.
// Contents:
//   sched_state_e   : scheduler FSM states (IDLE, GRANT, RELEASE)
//   N_REQ_DEFAULT   : default number of requesting leaves
//   TIMEOUT_DEFAULT : default maximum grant hold in cycles
//   next_idx()      : index increment with explicit wrap at n_req-1
package leaf_sched_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } sched_state_e;

   localparam int N_REQ_DEFAULT   = 15;
   localparam int TIMEOUT_DEFAULT = 255;

   // Wrap by comparing against the last index, so a leaf count that is not a
   // power of two still rotates correctly.
   function automatic int unsigned next_idx(input int unsigned idx,
                                            input int unsigned n_req);
      if (idx == n_req - 32'd1) begin
         return 32'd0;
      end else begin
         return idx + 32'd1;
      end
   endfunction

endpackage

// File: rtl/leaf_rr_pick.sv
// Combinational round-robin picker.
// Finds the first set request bit at or above ptr, wrapping from N_REQ-1 to 0.
// Ports:
//   req     in  N_REQ  request vector
//   ptr     in  IDX_W  index with highest priority (0..N_REQ-1)
//   found   out 1      at least one request bit is set
//   sel_idx out IDX_W  selected index (meaningful only when found=1)
module leaf_rr_pick
   import leaf_sched_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEFAULT,
   parameter int IDX_W = 4
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             found,
   output logic [IDX_W-1:0] sel_idx
);

   localparam logic [IDX_W:0] N_REQ_W = (IDX_W+1)'(N_REQ);
   localparam logic [IDX_W:0] LAST_W  = (IDX_W+1)'(N_REQ - 1);

   logic [N_REQ-1:0] rot_s;
   logic [IDX_W-1:0] off_s;
   logic             found_s;
   logic [IDX_W:0]   sum_s;
   logic [IDX_W:0]   wrap_s;

   // Rotate so that bit ptr lands at position 0; a shift by N_REQ yields zero.
   always_comb begin
      rot_s = (req >> ptr) | (req << (N_REQ_W - {1'b0, ptr}));
   end

   // Priority-find the lowest set bit of the rotated vector.
   always_comb begin
      found_s = 1'b0;
      off_s   = {IDX_W{1'b0}};
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot_s[i]) begin
            found_s = 1'b1;
            off_s   = IDX_W'(i);
         end else begin
            // lower positions processed later take precedence
         end
      end
   end

   // Un-rotate: add ptr back and fold values past the last leaf.
   always_comb begin
      sum_s = {1'b0, ptr} + {1'b0, off_s};
      if (sum_s > LAST_W) begin
         wrap_s = sum_s - N_REQ_W;
      end else begin
         wrap_s = sum_s;
      end
   end

   assign found   = found_s;
   assign sel_idx = wrap_s[IDX_W-1:0];

endmodule

// File: rtl/leaf_rr_scheduler.sv
// Round-robin scheduler sharing one execution slot among N_REQ leaves.
// A grant is held until the granted leaf signals done or the hold timeout
// expires, followed by one release cycle and one arbitration cycle.
// Ports:
//   clk           in  1      system clock
//   rst           in  1      asynchronous active-high reset
//   en            in  1      enable; low blocks new grants only
//   req           in  N_REQ  per-leaf level request
//   done          in  N_REQ  per-leaf completion (granted bit honoured only)
//   gnt           out N_REQ  registered one-hot grant
//   gnt_valid     out 1      OR of gnt
//   gnt_idx       out IDX_W  index of granted (or last granted) leaf
//   timeout_pulse out 1      one-cycle pulse on forced release
//   grant_cnt     out CNT_W  saturating count of grants since reset
module leaf_rr_scheduler
   import leaf_sched_pkg::*;
#(
   parameter int N_REQ   = N_REQ_DEFAULT,
   parameter int IDX_W   = 4,
   parameter int TIMEOUT = TIMEOUT_DEFAULT,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] done,
   output logic [N_REQ-1:0] gnt,
   output logic             gnt_valid,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             timeout_pulse,
   output logic [CNT_W-1:0] grant_cnt
);

   sched_state_e     state_r, state_s;
   logic [IDX_W-1:0] ptr_r, ptr_s;
   logic [CNT_W-1:0] hold_r, hold_s;
   logic [N_REQ-1:0] gnt_r, gnt_s;
   logic             gnt_valid_r, gnt_valid_s;
   logic [IDX_W-1:0] gnt_idx_r, gnt_idx_s;
   logic             timeout_pulse_r, timeout_pulse_s;
   logic [CNT_W-1:0] grant_cnt_r, grant_cnt_s;

   logic             found_s;
   logic [IDX_W-1:0] sel_s;
   logic             done_hit_s;
   logic             hold_end_s;

   leaf_rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req     (req),
      .ptr     (ptr_r),
      .found   (found_s),
      .sel_idx (sel_s)
   );

   assign done_hit_s = done[gnt_idx_r];
   assign hold_end_s = (hold_r == CNT_W'(TIMEOUT - 1));

   // Next-state and next-output computation for the scheduler FSM.
   always_comb begin
      state_s         = state_r;
      ptr_s           = ptr_r;
      hold_s          = hold_r;
      gnt_s           = gnt_r;
      gnt_valid_s     = gnt_valid_r;
      gnt_idx_s       = gnt_idx_r;
      timeout_pulse_s = 1'b0;
      grant_cnt_s     = grant_cnt_r;
      case (state_r)
         IDLE: begin
            if (en && found_s) begin
               state_s     = GRANT;
               gnt_s       = N_REQ'(1'b1) << sel_s;
               gnt_valid_s = 1'b1;
               gnt_idx_s   = sel_s;
               hold_s      = {CNT_W{1'b0}};
               if (grant_cnt_r != {CNT_W{1'b1}}) begin
                  grant_cnt_s = grant_cnt_r + CNT_W'(1'b1);
               end else begin
                  grant_cnt_s = grant_cnt_r;
               end
            end else begin
               state_s = IDLE;
            end
         end
         GRANT: begin
            // done is checked first so a same-cycle done suppresses the timeout
            if (done_hit_s || hold_end_s) begin
               state_s         = RELEASE;
               gnt_s           = {N_REQ{1'b0}};
               gnt_valid_s     = 1'b0;
               timeout_pulse_s = ~done_hit_s;
               ptr_s           = IDX_W'(next_idx(32'(gnt_idx_r), 32'(N_REQ)));
            end else begin
               hold_s = hold_r + CNT_W'(1'b1);
            end
         end
         RELEASE: begin
            state_s = IDLE;
         end
         default: begin
            state_s     = IDLE;
            gnt_s       = {N_REQ{1'b0}};
            gnt_valid_s = 1'b0;
         end
      endcase
   end

   // State, pointer, counter and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r         <= IDLE;
         ptr_r           <= {IDX_W{1'b0}};
         hold_r          <= {CNT_W{1'b0}};
         gnt_r           <= {N_REQ{1'b0}};
         gnt_valid_r     <= 1'b0;
         gnt_idx_r       <= {IDX_W{1'b0}};
         timeout_pulse_r <= 1'b0;
         grant_cnt_r     <= {CNT_W{1'b0}};
      end else begin
         state_r         <= state_s;
         ptr_r           <= ptr_s;
         hold_r          <= hold_s;
         gnt_r           <= gnt_s;
         gnt_valid_r     <= gnt_valid_s;
         gnt_idx_r       <= gnt_idx_s;
         timeout_pulse_r <= timeout_pulse_s;
         grant_cnt_r     <= grant_cnt_s;
      end
   end

   assign gnt           = gnt_r;
   assign gnt_valid     = gnt_valid_r;
   assign gnt_idx       = gnt_idx_r;
   assign timeout_pulse = timeout_pulse_r;
   assign grant_cnt     = grant_cnt_r;

endmodule

// File: tb/tb_leaf_rr_scheduler.sv
// Directed self-checking bench for leaf_rr_scheduler.
// Two instances share stimulus: dut (TIMEOUT=8) and dut_t4 (TIMEOUT=4).
module tb_leaf_rr_scheduler;

   localparam int N_REQ = 15;
   localparam int IDX_W = 4;
   localparam int CNT_W = 16;

   logic             clk;
   logic             rst;
   logic             en;
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] done;

   logic [N_REQ-1:0] gnt, gnt_t4;
   logic             gnt_valid, gnt_valid_t4;
   logic [IDX_W-1:0] gnt_idx, gnt_idx_t4;
   logic             timeout_pulse, timeout_pulse_t4;
   logic [CNT_W-1:0] grant_cnt, grant_cnt_t4;

   int n_checks = 0;
   int n_errors = 0;

   leaf_rr_scheduler #(
      .N_REQ (N_REQ), .IDX_W (IDX_W), .TIMEOUT (8), .CNT_W (CNT_W)
   ) dut (
      .clk (clk), .rst (rst), .en (en), .req (req), .done (done),
      .gnt (gnt), .gnt_valid (gnt_valid), .gnt_idx (gnt_idx),
      .timeout_pulse (timeout_pulse), .grant_cnt (grant_cnt)
   );

   leaf_rr_scheduler #(
      .N_REQ (N_REQ), .IDX_W (IDX_W), .TIMEOUT (4), .CNT_W (CNT_W)
   ) dut_t4 (
      .clk (clk), .rst (rst), .en (en), .req (req), .done (done),
      .gnt (gnt_t4), .gnt_valid (gnt_valid_t4), .gnt_idx (gnt_idx_t4),
      .timeout_pulse (timeout_pulse_t4), .grant_cnt (grant_cnt_t4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      en   = 1'b0;
      req  = 15'h0000;
      done = 15'h0000;
      tick();
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_valid", 32'(gnt_valid), 32'h0);
      check("rst_idx", 32'(gnt_idx), 32'h0);
      check("rst_pulse", 32'(timeout_pulse), 32'h0);
      check("rst_cnt", 32'(grant_cnt), 32'h0);
      rst = 1'b0;
   endtask

   initial begin
      rst  = 1'b1;
      en   = 1'b0;
      req  = 15'h0000;
      done = 15'h0000;

      // Single requester, done 5 cycles after grant rises
      do_reset();
      en  = 1'b1;
      req = 15'h0004;
      tick();
      check("t1_gnt", 32'(gnt), 32'h0004);
      check("t1_idx", 32'(gnt_idx), 32'd2);
      check("t1_valid", 32'(gnt_valid), 32'd1);
      check("t1_cnt", 32'(grant_cnt), 32'd1);
      for (int k = 1; k <= 5; k++) begin
         tick();
         check("t1_hold", 32'(gnt), 32'h0004);
      end
      done = 15'h0004;
      tick();
      done = 15'h0000;
      req  = 15'h0000;
      check("t1_rel_gnt", 32'(gnt), 32'h0);
      check("t1_rel_valid", 32'(gnt_valid), 32'h0);
      check("t1_rel_pulse", 32'(timeout_pulse), 32'h0);
      check("t1_rel_idx", 32'(gnt_idx), 32'd2);
      tick();
      check("t1_idle_gnt", 32'(gnt), 32'h0);
      check("t1_idle_cnt", 32'(grant_cnt), 32'd1);

      // Round robin with wrap: all leaves requesting
      do_reset();
      en  = 1'b1;
      req = 15'h7fff;
      tick();
      for (int g = 0; g < 16; g++) begin
         check("t2_idx", 32'(gnt_idx), 32'(g % 15));
         check("t2_gnt", 32'(gnt), 32'd1 << (g % 15));
         if (g == 15) begin
            check("t2_cnt16", 32'(grant_cnt), 32'd16);
         end
         tick();
         done = 15'(32'd1 << (g % 15));
         tick();
         done = 15'h0000;
         check("t2_rel", 32'(gnt), 32'h0);
         tick();
         check("t2_arb", 32'(gnt), 32'h0);
         tick();
      end
      req = 15'h0000;

      // Timeout release after 8 cycles, then pointer moves past leaf 7
      do_reset();
      en  = 1'b1;
      req = 15'h0080;
      tick();
      check("t3_gnt", 32'(gnt), 32'h0080);
      for (int k = 1; k <= 7; k++) begin
         tick();
         check("t3_hold", 32'(gnt), 32'h0080);
         check("t3_nopulse", 32'(timeout_pulse), 32'h0);
      end
      tick();
      check("t3_to_gnt", 32'(gnt), 32'h0);
      check("t3_pulse", 32'(timeout_pulse), 32'h1);
      check("t3_to_valid", 32'(gnt_valid), 32'h0);
      req = 15'h0088;
      tick();
      check("t3_pulse_end", 32'(timeout_pulse), 32'h0);
      check("t3_idle_gnt", 32'(gnt), 32'h0);
      tick();
      check("t3_first3", 32'(gnt), 32'h0008);
      done = 15'h0008;
      tick();
      done = 15'h0000;
      tick();
      tick();
      check("t3_then7", 32'(gnt), 32'h0080);
      done = 15'h0080;
      tick();
      done = 15'h0000;
      req  = 15'h0000;
      tick();

      // Done/timeout collision on the TIMEOUT=4 instance; foreign done ignored
      do_reset();
      en  = 1'b1;
      req = 15'h0020;
      tick();
      check("t4_gnt", 32'(gnt_t4), 32'h0020);
      done = 15'h0040;
      tick();
      done = 15'h0000;
      check("t4_foreign", 32'(gnt_t4), 32'h0020);
      req = 15'h0000;
      tick();
      check("t4_reqdrop", 32'(gnt_t4), 32'h0020);
      tick();
      check("t4_c3", 32'(gnt_t4), 32'h0020);
      done = 15'h0020;
      tick();
      done = 15'h0000;
      check("t4_rel", 32'(gnt_t4), 32'h0);
      check("t4_nopulse", 32'(timeout_pulse_t4), 32'h0);
      check("t4_cnt", 32'(grant_cnt_t4), 32'd1);
      tick();
      check("t4_idle_pulse", 32'(timeout_pulse_t4), 32'h0);

      // Enable gating
      do_reset();
      en  = 1'b1;
      req = 15'h0002;
      tick();
      check("t5_gnt", 32'(gnt), 32'h0002);
      en = 1'b0;
      tick();
      check("t5_en_off", 32'(gnt), 32'h0002);
      done = 15'h0002;
      tick();
      done = 15'h0000;
      req  = 15'h0300;
      check("t5_rel", 32'(gnt), 32'h0);
      check("t5_rel_idx", 32'(gnt_idx), 32'd1);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("t5_blocked", 32'(gnt), 32'h0);
      end
      check("t5_cnt", 32'(grant_cnt), 32'd1);
      en = 1'b1;
      tick();
      check("t5_gnt2", 32'(gnt), 32'h0100);
      check("t5_idx2", 32'(gnt_idx), 32'd8);
      check("t5_cnt2", 32'(grant_cnt), 32'd2);
      done = 15'h0100;
      tick();
      done = 15'h0000;
      req  = 15'h0000;
      tick();

      // Asynchronous reset mid-grant clears the pointer
      do_reset();
      en  = 1'b1;
      req = 15'h0200;
      tick();
      check("t6_g9", 32'(gnt), 32'h0200);
      done = 15'h0200;
      tick();
      done = 15'h0000;
      req  = 15'h0400;
      tick();
      tick();
      check("t6_g10", 32'(gnt), 32'h0400);
      check("t6_cnt2", 32'(grant_cnt), 32'd2);
      #2;
      rst = 1'b1;
      #1;
      check("t6_async_gnt", 32'(gnt), 32'h0);
      check("t6_async_valid", 32'(gnt_valid), 32'h0);
      check("t6_async_cnt", 32'(grant_cnt), 32'h0);
      check("t6_async_idx", 32'(gnt_idx), 32'h0);
      req = 15'h0401;
      tick();
      rst = 1'b0;
      tick();
      check("t6_ptr0_gnt", 32'(gnt), 32'h0001);
      check("t6_ptr0_idx", 32'(gnt_idx), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
